// File: rtl/usb_sniffer_pkg.sv
// Shared types and constants for the USB sniffer capture path.
package usb_sniffer_pkg;

    localparam int USB_SNIFFER_WORD_W = 32;

    typedef enum logic {
        ARB_STATE_IDLE   = 1'b0,
        ARB_STATE_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/usb_sniffer_rr_pick.sv
// Rotating-priority selector: first valid requester after rr_ptr_i.
module usb_sniffer_rr_pick
    import usb_sniffer_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [REQ_W-1:0]   rr_ptr_i,
    output logic [REQ_W-1:0]   pick_o,
    output logic               any_o
);

    int idx;

    // Scan farthest-first so the nearest valid requester is written last.
    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        idx    = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(rr_ptr_i) + i) % NUM_REQ;
            if (valid_i[idx]) begin
                pick_o = REQ_W'(idx);
                any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_sniffer_fifo_arb.sv
// Round-robin record arbiter for the sniffer capture FIFO push port.
// Optional stall counter enabled by USB_SNIFFER_ARB_STATS_EN.
module usb_sniffer_fifo_arb
    import usb_sniffer_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [USB_SNIFFER_WORD_W*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]                 req_last_i,
    output logic [NUM_REQ-1:0]                 req_accept_o,
    output logic [USB_SNIFFER_WORD_W-1:0]      fifo_data_o,
    output logic                               fifo_push_o,
    input  logic                               fifo_accept_i,
    output logic [REQ_W-1:0]                   grant_o,
`ifdef USB_SNIFFER_ARB_STATS_EN
    input  logic                               stats_clr_i,
    output logic [15:0]                        stats_stall_o,
`endif
    output logic                               busy_o
);

    arb_state_e       state_q, state_d;
    logic [REQ_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0] grant_q, grant_d;
    logic [REQ_W-1:0] pick;
    logic             any;

    usb_sniffer_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_pick (
        .valid_i  (req_valid_i),
        .rr_ptr_i (rr_ptr_q),
        .pick_o   (pick),
        .any_o    (any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_STATE_IDLE;
            rr_ptr_q <= REQ_W'(NUM_REQ - 1);
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        fifo_push_o  = 1'b0;
        fifo_data_o  = '0;
        req_accept_o = '0;
        grant_o      = rr_ptr_q;
        unique case (state_q)
            ARB_STATE_IDLE: begin
                if (any) begin
                    grant_o           = pick;
                    fifo_push_o       = 1'b1;
                    fifo_data_o       = req_data_i[USB_SNIFFER_WORD_W*pick +: USB_SNIFFER_WORD_W];
                    req_accept_o[pick] = fifo_accept_i;
                    if (fifo_accept_i) begin
                        if (req_last_i[pick]) begin
                            rr_ptr_d = pick;
                        end else begin
                            state_d = ARB_STATE_LOCKED;
                            grant_d = pick;
                        end
                    end
                end
            end
            ARB_STATE_LOCKED: begin
                grant_o = grant_q;
                // Owner bubbles keep the lock so the record stays contiguous.
                if (req_valid_i[grant_q]) begin
                    fifo_push_o           = 1'b1;
                    fifo_data_o           = req_data_i[USB_SNIFFER_WORD_W*grant_q +: USB_SNIFFER_WORD_W];
                    req_accept_o[grant_q] = fifo_accept_i;
                    if (fifo_accept_i && req_last_i[grant_q]) begin
                        state_d  = ARB_STATE_IDLE;
                        rr_ptr_d = grant_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q == ARB_STATE_LOCKED);

`ifdef USB_SNIFFER_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (stats_clr_i) begin
            stall_d = '0;
        end else if (fifo_push_o && !fifo_accept_i && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stats_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_usb_sniffer_fifo_arb.sv
// Directed self-checking bench for usb_sniffer_fifo_arb.
module tb_usb_sniffer_fifo_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   valid;
    logic [127:0] data;
    logic [3:0]   last;
    logic [3:0]   acc;
    logic [31:0]  fdata;
    logic         push;
    logic         faccept;
    logic [1:0]   grant;
    logic         busy;
`ifdef USB_SNIFFER_ARB_STATS_EN
    logic         clr;
    logic [15:0]  stall;
`endif

    int vec = 0;
    int mis = 0;

    always #5 clk = ~clk;

    usb_sniffer_fifo_arb #(.NUM_REQ(4), .REQ_W(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (valid),
        .req_data_i    (data),
        .req_last_i    (last),
        .req_accept_o  (acc),
        .fifo_data_o   (fdata),
        .fifo_push_o   (push),
        .fifo_accept_i (faccept),
        .grant_o       (grant),
`ifdef USB_SNIFFER_ARB_STATS_EN
        .stats_clr_i   (clr),
        .stats_stall_o (stall),
`endif
        .busy_o        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid   = '0;
        last    = '0;
        data    = '0;
        faccept = 1'b1;
        rst_n   = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        valid   = '0;
        last    = '0;
        data    = '0;
        faccept = 1'b1;
        rst_n   = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, push, acc, grant} !== {1'b0, 1'b0, 4'b0000, 2'd3}) begin
            mis++;
            $display("FAIL reset busy/push/acc/grant got %b %b %b %0d want 0 0 0000 3",
                     busy, push, acc, grant);
        end
        vec++;
        if (fdata !== 32'h0) begin
            mis++;
            $display("FAIL reset_data got %h want 0", fdata);
        end
`ifdef USB_SNIFFER_ARB_STATS_EN
        vec++;
        if (stall !== 16'd0) begin
            mis++;
            $display("FAIL reset_stall got %0d want 0", stall);
        end
`endif
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        do_reset();
        valid = 4'b0010;
        last  = 4'b0010;
        data[63:32] = 32'h1111_1111;
        @(negedge clk);
        vec++;
        if ({push, fdata, acc, grant, busy} !== {1'b1, 32'h1111_1111, 4'b0010, 2'd1, 1'b0}) begin
            mis++;
            $display("FAIL single push=%b data=%h acc=%b grant=%0d busy=%b want 1 11111111 0010 1 0",
                     push, fdata, acc, grant, busy);
        end
        tick();
        valid = '0;
        @(negedge clk);
        vec++;
        if ({push, busy, grant} !== {1'b0, 1'b0, 2'd1}) begin
            mis++;
            $display("FAIL single_after push=%b busy=%b grant=%0d want 0 0 1", push, busy, grant);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        do_reset();
        valid = 4'b1111;
        last  = 4'b1111;
        for (int n = 0; n < 4; n++) data[32*n +: 32] = 32'hD0 + n;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vec++;
            if ({push, grant, fdata, acc} !==
                {1'b1, 2'(exp_g[c]), 32'hD0 + 32'(exp_g[c]), 4'b0001 << exp_g[c]}) begin
                mis++;
                $display("FAIL rr_cycle%0d push=%b grant=%0d data=%h acc=%b want grant %0d",
                         c, push, grant, fdata, acc, exp_g[c]);
            end
            tick();
        end
        valid = '0;
    endtask

    task automatic test_record_contiguity();
        logic [31:0] w [3] = '{32'hA0, 32'hA1, 32'hA2};
        do_reset();
        valid = 4'b0101;
        last  = 4'b0100;
        data[95:64] = 32'hC2;
        for (int c = 0; c < 3; c++) begin
            data[31:0] = w[c];
            last[0]    = (c == 2);
            @(negedge clk);
            vec++;
            if ({push, fdata, acc, busy, grant} !== {1'b1, w[c], 4'b0001, 1'(c != 0), 2'd0}) begin
                mis++;
                $display("FAIL contig_w%0d push=%b data=%h acc=%b busy=%b grant=%0d want data %h",
                         c, push, fdata, acc, busy, grant, w[c]);
            end
            tick();
        end
        valid[0] = 1'b0;
        @(negedge clk);
        vec++;
        if ({push, fdata, acc, busy, grant} !== {1'b1, 32'hC2, 4'b0100, 1'b0, 2'd2}) begin
            mis++;
            $display("FAIL contig_next data=%h acc=%b busy=%b grant=%0d want c2 0100 0 2",
                     fdata, acc, busy, grant);
        end
        tick();
        valid = '0;
    endtask

    task automatic test_owner_bubble();
        do_reset();
        valid = 4'b0011;
        last  = 4'b0010;
        data[31:0]  = 32'hB0;
        data[63:32] = 32'hE1;
        @(negedge clk);
        vec++;
        if ({fdata, acc} !== {32'hB0, 4'b0001}) begin
            mis++;
            $display("FAIL bubble_w0 data=%h acc=%b want b0 0001", fdata, acc);
        end
        tick();
        valid[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vec++;
            if ({push, acc, busy, grant, fdata} !== {1'b0, 4'b0000, 1'b1, 2'd0, 32'h0}) begin
                mis++;
                $display("FAIL bubble_gap%0d push=%b acc=%b busy=%b grant=%0d data=%h want 0 0000 1 0 0",
                         c, push, acc, busy, grant, fdata);
            end
            tick();
        end
        valid[0]   = 1'b1;
        data[31:0] = 32'hB1;
        @(negedge clk);
        vec++;
        if ({push, fdata, acc, busy} !== {1'b1, 32'hB1, 4'b0001, 1'b1}) begin
            mis++;
            $display("FAIL bubble_w1 data=%h acc=%b busy=%b want b1 0001 1", fdata, acc, busy);
        end
        tick();
        data[31:0] = 32'hB2;
        last[0]    = 1'b1;
        @(negedge clk);
        vec++;
        if ({fdata, acc} !== {32'hB2, 4'b0001}) begin
            mis++;
            $display("FAIL bubble_w2 data=%h acc=%b want b2 0001", fdata, acc);
        end
        tick();
        valid[0] = 1'b0;
        @(negedge clk);
        vec++;
        if ({fdata, acc, grant, busy} !== {32'hE1, 4'b0010, 2'd1, 1'b0}) begin
            mis++;
            $display("FAIL bubble_next data=%h acc=%b grant=%0d busy=%b want e1 0010 1 0",
                     fdata, acc, grant, busy);
        end
        tick();
        valid = '0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        valid = 4'b0001;
        last  = 4'b0000;
        data[31:0] = 32'hF0;
        tick();
        data[31:0] = 32'hF1;
        faccept    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vec++;
            if ({push, fdata, acc, busy} !== {1'b1, 32'hF1, 4'b0000, 1'b1}) begin
                mis++;
                $display("FAIL full_stall%0d push=%b data=%h acc=%b busy=%b want 1 f1 0000 1",
                         c, push, fdata, acc, busy);
            end
            tick();
        end
        faccept = 1'b1;
        @(negedge clk);
        vec++;
        if ({fdata, acc} !== {32'hF1, 4'b0001}) begin
            mis++;
            $display("FAIL full_resume data=%h acc=%b want f1 0001", fdata, acc);
        end
        tick();
        data[31:0] = 32'hF2;
        last[0]    = 1'b1;
        tick();
        valid = '0;
        @(negedge clk);
        vec++;
        if (busy !== 1'b0) begin
            mis++;
            $display("FAIL full_end busy=%b want 0", busy);
        end
`ifdef USB_SNIFFER_ARB_STATS_EN
        vec++;
        if (stall !== 16'd5) begin
            mis++;
            $display("FAIL stats_count got %0d want 5", stall);
        end
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        vec++;
        if (stall !== 16'd0) begin
            mis++;
            $display("FAIL stats_clear got %0d want 0", stall);
        end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        valid = 4'b1000;
        last  = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            data[127:96] = 32'h300 + c;
            @(negedge clk);
            vec++;
            if ({push, fdata, acc, grant} !== {1'b1, 32'h300 + 32'(c), 4'b1000, 2'd3}) begin
                mis++;
                $display("FAIL b2b_%0d push=%b data=%h acc=%b grant=%0d want 1 %h 1000 3",
                         c, push, fdata, acc, grant, 32'h300 + c);
            end
            tick();
        end
        valid = '0;
    endtask

    task automatic test_reset_mid_record();
        do_reset();
        valid = 4'b0001;
        last  = 4'b0000;
        data[31:0] = 32'h60;
        tick();
        data[31:0]  = 32'h61;
        data[63:32] = 32'h71;
        valid       = 4'b0011;
        last        = 4'b0010;
        @(negedge clk);
        vec++;
        if (busy !== 1'b1) begin
            mis++;
            $display("FAIL midrst_locked busy=%b want 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if ({busy, grant} !== {1'b0, 2'd0}) begin
            mis++;
            $display("FAIL midrst_async busy=%b grant=%0d want 0 0", busy, grant);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        vec++;
        if ({grant, fdata, acc, busy} !== {2'd0, 32'h61, 4'b0001, 1'b0}) begin
            mis++;
            $display("FAIL midrst_after grant=%0d data=%h acc=%b busy=%b want 0 61 0001 0",
                     grant, fdata, acc, busy);
        end
        tick();
        valid = '0;
    endtask

    initial begin
`ifdef USB_SNIFFER_ARB_STATS_EN
        clr = 1'b0;
`endif
        test_reset();
        test_single_word();
        test_round_robin();
        test_record_contiguity();
        test_owner_bubble();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid_record();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
